// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - instruction RAM loader: byte stream in, fetch read port out, processor reset gating
module imem_loader #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rstd,
  input  logic          load_start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic [AW+1:0] rd_addr,
  output logic [31:0]   rd_data,
  output logic          cpu_rstd,
  output logic          busy,
  output logic          load_done,
  output logic          err,
  output logic [AW:0]   word_count
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_CHECK,
    S_RELEASE
  } state_t;

  state_t state, state_nx;

  logic [31:0] mem [0:DEPTH-1];
  logic [AW:0] n_words;
  logic [1:0]  byte_idx;
  logic [23:0] hold;
  logic [7:0]  csum;

  logic xfer;
  logic count_bad;
  logic word_end;
  logic mem_we;
  logic [AW:0] count_inc;

  assign xfer      = in_valid && in_ready;
  assign count_bad = (in_data == 8'd0) || (int'(in_data) > DEPTH);
  assign word_end  = (byte_idx == 2'd3);
  assign count_inc = word_count + ONE;

  // Only the word index selects a RAM entry; the byte lane bits are don't-care.
  logic unused_rd_lane;
  assign unused_rd_lane = &{1'b0, rd_addr[1:0]};
  assign rd_data = mem[rd_addr[AW+1:2]];

  always_comb begin
    state_nx  = state;
    mem_we    = 1'b0;
    in_ready  = 1'b0;
    busy      = (state != S_IDLE);
    load_done = (state == S_RELEASE);
    case (state)
      S_IDLE: begin
        if (load_start) state_nx = S_COUNT;
      end
      S_COUNT: begin
        in_ready = 1'b1;
        if (xfer) state_nx = count_bad ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (xfer && word_end) begin
          mem_we = 1'b1;
          if (count_inc == n_words) state_nx = S_CHECK;
        end
      end
      S_CHECK: begin
        in_ready = 1'b1;
        if (xfer) state_nx = (in_data == csum) ? S_RELEASE : S_IDLE;
      end
      S_RELEASE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      cpu_rstd   <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
      n_words    <= '0;
      byte_idx   <= 2'd0;
      hold       <= 24'd0;
      csum       <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_start) begin
            cpu_rstd   <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
            csum       <= 8'd0;
          end
        end
        S_COUNT: begin
          if (xfer) begin
            n_words  <= in_data[AW:0];
            byte_idx <= 2'd0;
            if (count_bad) err <= 1'b1;
          end
        end
        S_DATA: begin
          if (xfer) begin
            csum     <= csum ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            if (word_end) begin
              word_count <= count_inc;
            end else begin
              hold <= {hold[15:0], in_data};
            end
          end
        end
        S_CHECK: begin
          if (xfer && (in_data != csum)) err <= 1'b1;
        end
        S_RELEASE: begin
          cpu_rstd <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // RAM has no reset so its contents survive an aborted load.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_count[AW-1:0]] <= {hold, in_data};
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed-vector bench for imem_loader
module tb_imem_loader;

  localparam int AW = 6;

  logic          clk;
  logic          rstd;
  logic          load_start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic [AW+1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          cpu_rstd;
  logic          busy;
  logic          load_done;
  logic          err;
  logic [AW:0]   word_count;

  int vectors;
  int miscompares;
  logic [31:0] ld_words [0:3];

  imem_loader #(.AW(AW)) dut (
    .clk        (clk),
    .rstd       (rstd),
    .load_start (load_start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cpu_rstd   (cpu_rstd),
    .busy       (busy),
    .load_done  (load_done),
    .err        (err),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xsum(input int n);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < n; i++) s = s ^ ld_words[i][31:24] ^ ld_words[i][23:16]
                                      ^ ld_words[i][15:8] ^ ld_words[i][7:0];
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Returns #1 after the edge on which the byte was taken.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int tmo;
    in_valid = 1'b1;
    in_data  = b;
    tmo = 0;
    while (!in_ready && tmo < 50) begin
      tick();
      tmo++;
    end
    if (tmo >= 50) chk("ready_timeout", 32'(in_ready), 32'd1);
    tick();
    if (gap) begin
      in_valid = 1'b0;
      tick();
      chk("ready_in_gap", 32'(in_ready), 32'd1);
    end
  endtask

  task automatic do_load(input int n, input logic [7:0] cs, input bit gap);
    start_load();
    chk("cpu_rstd_drop", 32'(cpu_rstd), 32'd0);
    chk("busy_after_start", 32'(busy), 32'd1);
    send_byte(8'(n), gap);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 4; j++)
        send_byte(ld_words[i][31-8*j -: 8], gap);
    send_byte(cs, 1'b0);
    in_valid = 1'b0;
  endtask

  task automatic expect_release(input string tag, input int n);
    chk({tag, "_done"}, 32'(load_done), 32'd1);
    chk({tag, "_rst_hold"}, 32'(cpu_rstd), 32'd0);
    chk({tag, "_count"}, 32'(word_count), 32'(n));
    chk({tag, "_err"}, 32'(err), 32'd0);
    tick();
    chk({tag, "_done_clr"}, 32'(load_done), 32'd0);
    chk({tag, "_rst_rel"}, 32'(cpu_rstd), 32'd1);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    rd_addr = a;
    #1;
    chk(tag, rd_data, exp);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstd        = 1'b0;
    load_start  = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    rd_addr     = '0;
    repeat (3) tick();
    chk("rst_cpu_rstd", 32'(cpu_rstd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    rstd = 1'b1;

    for (int i = 0; i < 20; i++) begin
      tick();
      chk("noload_cpu_rstd", 32'(cpu_rstd), 32'd0);
      chk("noload_busy", 32'(busy), 32'd0);
      chk("noload_ready", 32'(in_ready), 32'd0);
    end
    chk("noload_err", 32'(err), 32'd0);

    // Two words, in_valid held high; checksum of the data bytes is 0x93.
    ld_words[0] = 32'h8C010004;
    ld_words[1] = 32'h00221820;
    do_load(2, 8'h93, 1'b0);
    expect_release("ld2", 2);
    rd("rd_a00", 8'h00, 32'h8C010004);
    rd("rd_a04", 8'h04, 32'h00221820);
    rd("rd_a07", 8'h07, 32'h00221820);

    // Same load with in_valid toggling.
    do_load(2, 8'h93, 1'b1);
    expect_release("ld2gap", 2);
    rd("gap_a03", 8'h03, 32'h8C010004);
    rd("gap_a05", 8'h05, 32'h00221820);

    // Bad checksum (0x00 instead of 0x08).
    ld_words[0] = 32'h12345678;
    do_load(1, 8'h00, 1'b0);
    chk("badcs_err", 32'(err), 32'd1);
    chk("badcs_done", 32'(load_done), 32'd0);
    chk("badcs_cpu", 32'(cpu_rstd), 32'd0);
    chk("badcs_busy", 32'(busy), 32'd0);
    tick();
    chk("badcs_cpu_later", 32'(cpu_rstd), 32'd0);
    rd("badcs_mem0", 8'h00, 32'h12345678);
    do_load(1, xsum(1), 1'b0);
    expect_release("ld1", 1);

    // Illegal count bytes.
    start_load();
    send_byte(8'h00, 1'b0);
    in_valid = 1'b0;
    chk("n0_err", 32'(err), 32'd1);
    chk("n0_busy", 32'(busy), 32'd0);
    chk("n0_ready", 32'(in_ready), 32'd0);
    chk("n0_cpu", 32'(cpu_rstd), 32'd0);
    start_load();
    chk("n65_err_clr", 32'(err), 32'd0);
    send_byte(8'h41, 1'b0);
    in_valid = 1'b0;
    chk("n65_err", 32'(err), 32'd1);
    chk("n65_busy", 32'(busy), 32'd0);
    chk("n65_ready", 32'(in_ready), 32'd0);

    // Reset in the middle of a load.
    ld_words[0] = 32'h8C010004;
    ld_words[1] = 32'h00221820;
    do_load(2, 8'h93, 1'b0);
    expect_release("ld2b", 2);
    start_load();
    chk("reload_cpu", 32'(cpu_rstd), 32'd0);
    send_byte(8'h02, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    in_valid = 1'b0;
    rstd = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cpu", 32'(cpu_rstd), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    chk("midrst_count", 32'(word_count), 32'd0);
    tick();
    rstd = 1'b1;
    rd("midrst_mem0", 8'h00, 32'h8C010004);

    // load_start while busy is ignored.
    start_load();
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    in_valid = 1'b0;
    chk("busy_pre_count", 32'(word_count), 32'd1);
    start_load();
    chk("busy_start_count", 32'(word_count), 32'd1);
    chk("busy_start_busy", 32'(busy), 32'd1);
    chk("busy_start_ready", 32'(in_ready), 32'd1);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    send_byte(8'h88, 1'b0);
    in_valid = 1'b0;
    expect_release("ldlast", 2);
    rd("last_a00", 8'h00, 32'h11223344);
    rd("last_a04", 8'h04, 32'h55667788);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
